// File: rtl/gun_multi_ctrl.sv
// NES light-gun front end: per-gun pin synchronisers, trigger debounce FSM,
// sticky pull/missed interrupt flags and a post-pull light-sample window.
module gun_multi_ctrl #(
    parameter int NUM_GUNS         = 2,
    parameter int CNT_W            = 11,
    parameter int REL_CNT          = 2047,
    parameter int PRESS_CNT        = 2047,
    parameter int WIN_W            = 16,
    parameter int LIGHT_WIN        = 50000,
    parameter int TRIG_ACTIVE_LOW  = 1,
    parameter int LIGHT_ACTIVE_LOW = 0
) (
    input  logic                SYSTEM_Clock,
    input  logic                SYSTEM_Rst,
    input  logic [NUM_GUNS-1:0] GUN_Trigger,
    input  logic [NUM_GUNS-1:0] GUN_Light,
    input  logic [NUM_GUNS-1:0] Read,
    output logic [NUM_GUNS-1:0] Trigger_Pull,
    output logic [NUM_GUNS-1:0] Missed,
    output logic [NUM_GUNS-1:0] Light,
    output logic [NUM_GUNS-1:0] Hit,
    output logic [NUM_GUNS-1:0] Hit_Valid
);

    typedef enum logic {
        WAIT_REL,
        ARMED
    } state_t;

    localparam logic             TRIG_INV   = (TRIG_ACTIVE_LOW != 0);
    localparam logic             LIGHT_INV  = (LIGHT_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(REL_CNT - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CNT - 1);
    localparam logic [WIN_W-1:0] WIN_LOAD   = WIN_W'(LIGHT_WIN);

    logic [NUM_GUNS-1:0] trig_s1, trig_s2;
    logic [NUM_GUNS-1:0] light_s1, light_s2;
    logic [NUM_GUNS-1:0] pressed, lit;

    always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
        if (SYSTEM_Rst) begin
            trig_s1  <= '0;
            trig_s2  <= '0;
            light_s1 <= '0;
            light_s2 <= '0;
        end else begin
            trig_s1  <= GUN_Trigger;
            trig_s2  <= trig_s1;
            light_s1 <= GUN_Light;
            light_s2 <= light_s1;
        end
    end

    assign pressed = trig_s2 ^ {NUM_GUNS{TRIG_INV}};
    assign lit     = light_s2 ^ {NUM_GUNS{LIGHT_INV}};
    assign Light   = light_s2;

    for (genvar g = 0; g < NUM_GUNS; g++) begin : gun
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             fire;
        logic [WIN_W-1:0] win_q;
        logic             tp_q, missed_q, hit_q, hit_valid_q;

        always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
            if (SYSTEM_Rst) begin
                state_q <= WAIT_REL;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // The terminal compare is checked before incrementing, so cnt never wraps.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            fire    = 1'b0;
            case (state_q)
                WAIT_REL: begin
                    if (pressed[g]) begin
                        cnt_d = '0;
                    end else if (cnt_q == REL_LAST) begin
                        cnt_d   = '0;
                        state_d = ARMED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ARMED: begin
                    if (!pressed[g]) begin
                        cnt_d = '0;
                    end else if (cnt_q == PRESS_LAST) begin
                        cnt_d   = '0;
                        fire    = 1'b1;
                        state_d = WAIT_REL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end
            endcase
        end

        // A pull on the same edge as Read wins over the clear and never counts as missed.
        always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
            if (SYSTEM_Rst) begin
                tp_q     <= 1'b0;
                missed_q <= 1'b0;
            end else if (fire) begin
                tp_q     <= 1'b1;
                missed_q <= Read[g] ? 1'b0 : (missed_q | tp_q);
            end else if (Read[g]) begin
                tp_q     <= 1'b0;
                missed_q <= 1'b0;
            end
        end

        always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
            if (SYSTEM_Rst) begin
                win_q       <= '0;
                hit_q       <= 1'b0;
                hit_valid_q <= 1'b0;
            end else if (fire) begin
                win_q       <= WIN_LOAD;
                hit_q       <= 1'b0;
                hit_valid_q <= 1'b0;
            end else if (win_q != '0) begin
                win_q <= win_q - WIN_W'(1);
                if (lit[g]) begin
                    hit_q <= 1'b1;
                end
                if (win_q == WIN_W'(1)) begin
                    hit_valid_q <= 1'b1;
                end
            end
        end

        assign Trigger_Pull[g] = tp_q;
        assign Missed[g]       = missed_q;
        assign Hit[g]          = hit_q;
        assign Hit_Valid[g]    = hit_valid_q;
    end

endmodule

// File: tb/tb_gun_multi_ctrl.sv
// Self-checking bench for gun_multi_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_gun_multi_ctrl;

    localparam int NG  = 2;
    localparam int REL = 4;
    localparam int PRS = 3;
    localparam int LW  = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NG-1:0] gunTrigger = '1;
    logic [NG-1:0] gunLight = '0;
    logic [NG-1:0] readStrobe = '0;
    logic [NG-1:0] triggerPull, missed, lightOut, hit, hitValid;

    int nCompared = 0;
    int nMismatched = 0;

    gun_multi_ctrl #(
        .NUM_GUNS(NG), .CNT_W(11), .REL_CNT(REL), .PRESS_CNT(PRS),
        .WIN_W(16), .LIGHT_WIN(LW), .TRIG_ACTIVE_LOW(1), .LIGHT_ACTIVE_LOW(0)
    ) dut (
        .SYSTEM_Clock(clock),
        .SYSTEM_Rst  (reset),
        .GUN_Trigger (gunTrigger),
        .GUN_Light   (gunLight),
        .Read        (readStrobe),
        .Trigger_Pull(triggerPull),
        .Missed      (missed),
        .Light       (lightOut),
        .Hit         (hit),
        .Hit_Valid   (hitValid)
    );

    always #20 clock = ~clock;

    // Reference model: pin pipeline delay plus run-length rules per gun
    bit mTrigD1[NG], mTrigD2[NG], mLightD1[NG], mLightD2[NG];
    bit mArmed[NG], mTp[NG], mMs[NG], mHit[NG], mHv[NG];
    int mRun[NG], mWinLeft[NG];

    task automatic modelReset();
        for (int g = 0; g < NG; g++) begin
            mTrigD1[g] = 0; mTrigD2[g] = 0; mLightD1[g] = 0; mLightD2[g] = 0;
            mArmed[g] = 0; mTp[g] = 0; mMs[g] = 0; mHit[g] = 0; mHv[g] = 0;
            mRun[g] = 0; mWinLeft[g] = 0;
        end
    endtask

    task automatic modelStep(input logic [NG-1:0] trig, input logic [NG-1:0] light,
                             input logic [NG-1:0] rd);
        for (int g = 0; g < NG; g++) begin
            bit isPressed;
            bit isLit;
            bit pulled;
            isPressed = !mTrigD2[g];
            isLit = mLightD2[g];
            pulled = 0;
            // Count the run of the level the gun is waiting for
            if (!mArmed[g]) begin
                mRun[g] = isPressed ? 0 : mRun[g] + 1;
                if (mRun[g] == REL) begin
                    mArmed[g] = 1;
                    mRun[g] = 0;
                end
            end else begin
                mRun[g] = isPressed ? mRun[g] + 1 : 0;
                if (mRun[g] == PRS) begin
                    pulled = 1;
                    mArmed[g] = 0;
                    mRun[g] = 0;
                end
            end
            if (pulled) begin
                mMs[g] = rd[g] ? 0 : (mMs[g] | mTp[g]);
                mTp[g] = 1;
                mWinLeft[g] = LW;
                mHit[g] = 0;
                mHv[g] = 0;
            end else begin
                if (rd[g]) begin
                    mTp[g] = 0;
                    mMs[g] = 0;
                end
                if (mWinLeft[g] > 0) begin
                    if (isLit) mHit[g] = 1;
                    if (mWinLeft[g] == 1) mHv[g] = 1;
                    mWinLeft[g] = mWinLeft[g] - 1;
                end
            end
            mTrigD2[g] = mTrigD1[g];
            mTrigD1[g] = trig[g];
            mLightD2[g] = mLightD1[g];
            mLightD1[g] = light[g];
        end
    endtask

    task automatic checkVal(input string name, input logic [NG-1:0] act, input logic [NG-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [NG-1:0] eTp, eMs, eLt, eHit, eHv;
        for (int g = 0; g < NG; g++) begin
            eTp[g] = mTp[g]; eMs[g] = mMs[g]; eLt[g] = mLightD2[g];
            eHit[g] = mHit[g]; eHv[g] = mHv[g];
        end
        checkVal({name, "/Trigger_Pull"}, triggerPull, eTp);
        checkVal({name, "/Missed"}, missed, eMs);
        checkVal({name, "/Light"}, lightOut, eLt);
        checkVal({name, "/Hit"}, hit, eHit);
        checkVal({name, "/Hit_Valid"}, hitValid, eHv);
    endtask

    task automatic applyStimulus(input logic [NG-1:0] trig, input logic [NG-1:0] light,
                                 input logic [NG-1:0] rd, input int n, input bit useModel);
        for (int c = 0; c < n; c++) begin
            gunTrigger = trig;
            gunLight = light;
            readStrobe = rd;
            modelStep(trig, light, rd);
            @(posedge clock);
            #1;
            if (useModel) checkOutput("random");
        end
        readStrobe = '0;
    endtask

    task automatic doReset(input string name);
        reset = 1'b1;
        modelReset();
        #2;
        checkVal({name, "/Trigger_Pull"}, triggerPull, 2'b00);
        checkVal({name, "/Missed"}, missed, 2'b00);
        checkVal({name, "/Light"}, lightOut, 2'b00);
        checkVal({name, "/Hit"}, hit, 2'b00);
        checkVal({name, "/Hit_Valid"}, hitValid, 2'b00);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NG-1:0] trig;
        logic [NG-1:0] light;
        logic [NG-1:0] rd;
        int            n;
        logic [NG-1:0] eTp;
        logic [NG-1:0] eMs;
        logic [NG-1:0] eHit;
        logic [NG-1:0] eHv;
    } vec_t;

    vec_t vecs[9];
    logic [NG-1:0] rTrig, rLight, rRd;

    initial begin
        // Gun 0 walk-through: arm, pull, hold, re-pull without read, then read
        vecs[0] = '{2'b11, 2'b00, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1] = '{2'b10, 2'b00, 2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2] = '{2'b10, 2'b00, 2'b00,  1, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[3] = '{2'b10, 2'b00, 2'b00,  5, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[4] = '{2'b10, 2'b00, 2'b00, 90, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[5] = '{2'b11, 2'b00, 2'b00,  4, 2'b01, 2'b00, 2'b00, 2'b01};
        vecs[6] = '{2'b10, 2'b00, 2'b00,  5, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[7] = '{2'b11, 2'b00, 2'b01,  1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[8] = '{2'b11, 2'b00, 2'b00,  4, 2'b00, 2'b00, 2'b00, 2'b01};

        doReset("reset");
        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].trig, vecs[i].light, vecs[i].rd, vecs[i].n, 1'b0);
            checkVal({tag, "/Trigger_Pull"}, triggerPull, vecs[i].eTp);
            checkVal({tag, "/Missed"}, missed, vecs[i].eMs);
            checkVal({tag, "/Hit"}, hit, vecs[i].eHit);
            checkVal({tag, "/Hit_Valid"}, hitValid, vecs[i].eHv);
        end

        // Short pressed glitch must not fire; a full press afterwards does
        doReset("glitchReset");
        applyStimulus(2'b11, 2'b00, 2'b00, 8, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 2, 1'b0);
        applyStimulus(2'b11, 2'b00, 2'b00, 6, 1'b0);
        checkVal("glitch/Trigger_Pull", triggerPull, 2'b00);
        applyStimulus(2'b10, 2'b00, 2'b00, 4, 1'b0);
        checkVal("press4/Trigger_Pull", triggerPull, 2'b00);
        applyStimulus(2'b10, 2'b00, 2'b00, 1, 1'b0);
        checkVal("press5/Trigger_Pull", triggerPull, 2'b01);

        // Second pull while pending, with Read on the qualifying edge
        applyStimulus(2'b11, 2'b00, 2'b00, 4, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 4, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b01, 1, 1'b0);
        checkVal("readOnEvent/Trigger_Pull", triggerPull, 2'b01);
        checkVal("readOnEvent/Missed", missed, 2'b00);

        // Light seen on window cycle 3, then light only after the window
        doReset("hitReset");
        applyStimulus(2'b11, 2'b00, 2'b00, 8, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 5, 1'b0);
        checkVal("hitEvent/Trigger_Pull", triggerPull, 2'b01);
        applyStimulus(2'b10, 2'b01, 2'b00, 1, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 1, 1'b0);
        checkVal("hitSync/Light", lightOut, 2'b01);
        applyStimulus(2'b10, 2'b00, 2'b00, 2, 1'b0);
        checkVal("hitWin4/Hit_Valid", hitValid, 2'b00);
        applyStimulus(2'b10, 2'b00, 2'b00, 1, 1'b0);
        checkVal("hitWin5/Hit", hit, 2'b01);
        checkVal("hitWin5/Hit_Valid", hitValid, 2'b01);
        applyStimulus(2'b11, 2'b00, 2'b00, 4, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 5, 1'b0);
        checkVal("late/Hit_Valid0", hitValid, 2'b00);
        applyStimulus(2'b10, 2'b00, 2'b00, 5, 1'b0);
        applyStimulus(2'b10, 2'b01, 2'b00, 4, 1'b0);
        checkVal("late/Hit", hit, 2'b00);
        checkVal("late/Hit_Valid", hitValid, 2'b01);

        // Reset while gun 0 is mid-press and gun 1's window is open
        doReset("midReset0");
        applyStimulus(2'b11, 2'b00, 2'b00, 8, 1'b0);
        applyStimulus(2'b01, 2'b10, 2'b00, 5, 1'b0);
        checkVal("gun1Event/Trigger_Pull", triggerPull, 2'b10);
        applyStimulus(2'b00, 2'b10, 2'b00, 3, 1'b0);
        doReset("midReset");
        applyStimulus(2'b11, 2'b00, 2'b00, 3, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 5, 1'b0);
        checkVal("noRearm/Trigger_Pull", triggerPull, 2'b00);
        applyStimulus(2'b11, 2'b00, 2'b00, 4, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 5, 1'b0);
        checkVal("rearm/Trigger_Pull", triggerPull, 2'b11);
        checkVal("rearm/Missed", missed, 2'b00);

        // Randomized traffic against the model
        doReset("randReset");
        rTrig = '1;
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NG; g++) begin
                if ($urandom_range(5) == 0) rTrig[g] = ~rTrig[g];
                rLight[g] = ($urandom_range(7) == 0);
                rRd[g] = ($urandom_range(9) == 0);
            end
            applyStimulus(rTrig, rLight, rRd, 1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
